bin_pack: RTL



---
 rtl/bin_pack.sv | 90 +++++++++
 1 files changed

// File: rtl/bin_pack.sv
`default_nettype none
// ============================================================================
//  Module   : bin_pack
//  Purpose  : Binarizes pooled signed values against a per-channel threshold
//             and packs the resulting bits LSB-first into PW-bit words.
//  Revision : 1.0 - initial release
// ============================================================================
module bin_pack #(
    parameter int DW = 32,
    parameter int PW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 state,
    input  logic                 ivalid,
    input  logic signed [DW-1:0] din,
    input  logic signed [DW-1:0] thresh,
    output logic                 ovalid,
    output logic [PW-1:0]        dout,
    output logic                 olast,
    output logic [7:0]           map_cnt
);

    localparam int              c_BW       = $clog2(PW);
    localparam logic [7:0]      c_LAST_L0  = 8'd143;   // 12x12 map
    localparam logic [7:0]      c_LAST_L1  = 8'd15;    // 4x4 map
    localparam logic [c_BW-1:0] c_BIDX_MAX = c_BW'(PW - 1);
    localparam logic [c_BW-1:0] c_BIDX_ONE = c_BW'(1);

    logic [7:0]      r_pix;
    logic [c_BW-1:0] r_bidx;
    logic [PW-1:0]   r_acc;
    logic            r_lay;

    logic            w_lay;
    logic [7:0]      w_last_pix;
    logic            w_bit;
    logic            w_word_end;
    logic            w_map_end;
    logic [PW-1:0]   w_acc_nxt;

    // The layer is taken live on pixel 0 so a back-to-back map starts with
    // the new layer in the very cycle it is latched.
    assign w_lay      = (r_pix == 8'd0) ? state : r_lay;
    assign w_last_pix = w_lay ? c_LAST_L1 : c_LAST_L0;
    assign w_bit      = (din >= thresh);
    assign w_word_end = (r_bidx == c_BIDX_MAX);
    assign w_map_end  = (r_pix == w_last_pix);

    always_comb begin
        w_acc_nxt         = r_acc;
        w_acc_nxt[r_bidx] = w_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix   <= 8'd0;
            r_bidx  <= '0;
            r_acc   <= '0;
            r_lay   <= 1'b0;
            ovalid  <= 1'b0;
            olast   <= 1'b0;
            dout    <= '0;
            map_cnt <= 8'd0;
        end else begin
            ovalid <= 1'b0;
            olast  <= 1'b0;
            if (ivalid) begin
                if (r_pix == 8'd0) begin
                    r_lay <= state;
                end
                r_pix  <= w_map_end  ? 8'd0 : r_pix + 8'd1;
                r_bidx <= w_word_end ? '0   : r_bidx + c_BIDX_ONE;
                if (w_word_end) begin
                    dout   <= w_acc_nxt;
                    ovalid <= 1'b1;
                    olast  <= w_map_end;
                    r_acc  <= '0;
                    if (w_map_end) begin
                        map_cnt <= map_cnt + 8'd1;
                    end
                end else begin
                    r_acc <= w_acc_nxt;
                end
            end
        end
    end

endmodule
`default_nettype wire
